// File: rtl/us_timebase.sv
// Microsecond timebase: divides the clock by exactly CLK_DIV into a one-cycle tick.
// A tick counter runs free, reloads periodically or fires once against a runtime compare.
module us_timebase #(
    parameter int unsigned CLK_DIV = 100,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_cmp,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_cnt_val,
    output logic             o_match,
    output logic             o_wrap,
    output logic             o_done
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] DIV_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ModeFree     = 2'd0,
        ModePeriodic = 2'd1,
        ModeOneShot  = 2'd2,
        ModeFreeRsvd = 2'd3
    } mode_e;

    logic [PW-1:0]    r_pre,   w_pre_d;
    logic [CNT_W-1:0] r_cnt,   w_cnt_d;
    logic             r_tick,  w_tick_d;
    logic             r_match, w_match_d;
    logic             r_wrap,  w_wrap_d;
    logic             r_done,  w_done_d;
    mode_e            w_mode;

    assign w_mode = mode_e'(i_mode);

    always_comb begin
        w_pre_d   = r_pre;
        w_cnt_d   = r_cnt;
        w_tick_d  = 1'b0;
        w_match_d = 1'b0;
        w_wrap_d  = 1'b0;
        w_done_d  = r_done;
        if (i_clr) begin
            w_pre_d  = '0;
            w_cnt_d  = '0;
            w_done_d = 1'b0;
        end else if (!r_done && i_en) begin
            if (r_pre == DIV_MAX) begin
                w_pre_d  = '0;
                w_tick_d = 1'b1;
                unique case (w_mode)
                    ModePeriodic: begin
                        if (r_cnt >= i_cmp) begin
                            w_cnt_d   = '0;
                            w_match_d = 1'b1;
                        end else begin
                            w_cnt_d = r_cnt + 1'b1;
                        end
                    end
                    ModeOneShot: begin
                        // Completion holds the count; r_done then freezes everything
                        if (r_cnt >= i_cmp) begin
                            w_match_d = 1'b1;
                            w_done_d  = 1'b1;
                        end else begin
                            w_cnt_d = r_cnt + 1'b1;
                        end
                    end
                    ModeFree, ModeFreeRsvd: begin
                        w_cnt_d   = r_cnt + 1'b1;
                        w_match_d = (r_cnt == i_cmp);
                        w_wrap_d  = (r_cnt == {CNT_W{1'b1}});
                    end
                    default: w_cnt_d = r_cnt;
                endcase
            end else begin
                w_pre_d = r_pre + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre   <= '0;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_match <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_pre   <= w_pre_d;
            r_cnt   <= w_cnt_d;
            r_tick  <= w_tick_d;
            r_match <= w_match_d;
            r_wrap  <= w_wrap_d;
            r_done  <= w_done_d;
        end
    end

    assign o_tick    = r_tick;
    assign o_cnt_val = r_cnt;
    assign o_match   = r_match;
    assign o_wrap    = r_wrap;
    assign o_done    = r_done;

endmodule
